// File: rtl/scroll_pixel_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | scroll_pixel_gen : side-scrolling obstacle game state and pixel colouring   |
// | Optional feature macro: SCORE_BAR_EN (score bar in the top 8 rows)          |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module scroll_pixel_gen #(
  parameter int N_OBS  = 4,
  parameter int OBS_W  = 150,
  parameter int OBS_H  = 30,
  parameter int BOX_SZ = 50,
  parameter int SPEED  = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        p_tick,
  input  logic        video_on,
  input  logic [9:0]  x,
  input  logic [9:0]  y,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_start,
  output logic [11:0] rgb,
  output logic        collision,
  output logic [7:0]  score
);

  localparam int c_SCR_W  = 640;
  localparam int c_BOX_X  = 40;
  localparam int c_PY_MAX = 480 - BOX_SZ;
  localparam int c_PY_RST = 200;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_HIT  = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t                r_state;
  logic [N_OBS-1:0][9:0] r_obs_x;
  logic [9:0]            r_py;
  logic [7:0]            r_score;
  logic [4:0]            r_frame_cnt;
  logic                  r_hit;
  logic                  r_collision;
  logic [11:0]           r_rgb;

  logic [N_OBS-1:0][9:0] w_obs_nxt;
  logic [N_OBS-1:0]      w_obs_pix;
  logic [N_OBS-1:0]      w_wrap;
  logic [2:0]            w_wrap_cnt;
  logic [8:0]            w_score_sum;
  logic [7:0]            w_score_nxt;
  logic [9:0]            w_py_nxt;
  logic [10:0]           w_x11;
  logic [10:0]           w_y11;
  logic                  w_box_pix;
  logic                  w_overlap;
  logic                  w_frame_tick;

  function automatic logic [N_OBS-1:0][9:0] obs_rst_val();
    logic [N_OBS-1:0][9:0] v;
    for (int i = 0; i < N_OBS; i++) v[i] = 10'(400 + i * 60);
    return v;
  endfunction

  assign w_x11        = {1'b0, x};
  assign w_y11        = {1'b0, y};
  assign w_frame_tick = p_tick && (x == 10'd0) && (y == 10'd480);

  generate
    for (genvar i = 0; i < N_OBS; i++) begin : g_obs
      localparam logic [10:0] c_TOP = 11'(60 + i * 100);
      localparam logic [10:0] c_BOT = 11'(60 + i * 100 + OBS_H);
      logic [10:0] w_right;

      assign w_right      = {1'b0, r_obs_x[i]} + 11'(OBS_W);
      // Columns past the right screen edge never light up, even mid-wrap.
      assign w_obs_pix[i] = (w_y11 >= c_TOP) && (w_y11 < c_BOT) &&
                            (w_x11 >= {1'b0, r_obs_x[i]}) && (w_x11 < w_right) &&
                            (w_x11 < 11'(c_SCR_W));
      assign w_wrap[i]    = r_obs_x[i] < 10'(SPEED);
      assign w_obs_nxt[i] = w_wrap[i] ? 10'(c_SCR_W) : r_obs_x[i] - 10'(SPEED);
    end
  endgenerate

  always_comb begin
    w_wrap_cnt = 3'd0;
    for (int i = 0; i < N_OBS; i++) w_wrap_cnt = w_wrap_cnt + 3'(w_wrap[i]);
  end

  assign w_score_sum = {1'b0, r_score} + 9'(w_wrap_cnt);
  assign w_score_nxt = w_score_sum[8] ? 8'hFF : w_score_sum[7:0];

  always_comb begin
    w_py_nxt = r_py;
    if (btn_up && !btn_down) begin
      w_py_nxt = (r_py < 10'd2) ? 10'd0 : r_py - 10'd2;
    end else if (btn_down && !btn_up) begin
      w_py_nxt = (({1'b0, r_py} + 11'd2) > 11'(c_PY_MAX)) ? 10'(c_PY_MAX) : r_py + 10'd2;
    end
  end

  assign w_box_pix = (w_x11 >= 11'(c_BOX_X)) && (w_x11 < 11'(c_BOX_X + BOX_SZ)) &&
                     (w_y11 >= {1'b0, r_py}) && (w_y11 < ({1'b0, r_py} + 11'(BOX_SZ)));
  assign w_overlap = w_box_pix && (|w_obs_pix);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_obs_x     <= obs_rst_val();
      r_py        <= 10'(c_PY_RST);
      r_score     <= 8'd0;
      r_frame_cnt <= 5'd0;
      r_hit       <= 1'b0;
      r_collision <= 1'b0;
    end else begin
      // The flag is consumed by the state logic on the same tick that clears it.
      if (w_frame_tick) begin
        r_hit <= 1'b0;
      end else if (video_on && p_tick && w_overlap) begin
        r_hit <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_frame_tick && btn_start) r_state <= S_PLAY;
        end
        S_PLAY: begin
          if (w_frame_tick) begin
            r_obs_x <= w_obs_nxt;
            r_score <= w_score_nxt;
            r_py    <= w_py_nxt;
            if (r_hit) begin
              r_state     <= S_HIT;
              r_frame_cnt <= 5'd0;
              r_collision <= 1'b1;
            end
          end
        end
        S_HIT: begin
          if (w_frame_tick) begin
            r_frame_cnt <= r_frame_cnt + 5'd1;
            if (r_frame_cnt == 5'd31) r_state <= S_OVER;
          end
        end
        S_OVER: begin
          if (btn_start) begin
            r_state     <= S_IDLE;
            r_collision <= 1'b0;
            r_obs_x     <= obs_rst_val();
            r_py        <= 10'(c_PY_RST);
            r_score     <= 8'd0;
            r_frame_cnt <= 5'd0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rgb <= 12'h000;
    end else if (p_tick) begin
      if (!video_on) begin
        r_rgb <= 12'h000;
`ifdef SCORE_BAR_EN
      end else if ((y < 10'd8) && (w_x11 < {2'b00, r_score, 1'b0})) begin
        r_rgb <= 12'h0FF;
`endif
      end else if (w_box_pix) begin
        r_rgb <= ((r_state == S_HIT) && r_frame_cnt[0]) ? 12'hFFF : 12'h0F0;
      end else if (|w_obs_pix) begin
        r_rgb <= 12'h00F;
      end else begin
        r_rgb <= 12'h000;
      end
    end
  end

  assign rgb       = r_rgb;
  assign collision = r_collision;
  assign score     = r_score;

endmodule
`default_nettype wire

// File: tb/tb_scroll_pixel_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_scroll_pixel_gen : bench for scroll_pixel_gen with a behavioural model   |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_scroll_pixel_gen;

`ifdef SCORE_BAR_EN
  localparam bit c_BAR = 1'b1;
`else
  localparam bit c_BAR = 1'b0;
`endif
  localparam int c_IDLE = 0, c_PLAY = 1, c_HIT = 2, c_OVER = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        p_tick = 1'b0, video_on = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic [9:0]  x = '0, y = '0;
  logic [11:0] rgb;
  logic        collision;
  logic [7:0]  score;

  int total = 0, bad = 0;

  // Game state as the rules describe it, in plain integers.
  int m_state, m_py, m_score, m_fc, m_rgb;
  int m_ox[4];
  bit m_hit;

  logic [3:0][9:0] f_obs;
  logic [7:0]      f_score;

  always #5 clk = ~clk;

  scroll_pixel_gen dut (
    .clk(clk), .reset_n(reset_n), .p_tick(p_tick), .video_on(video_on),
    .x(x), .y(y), .btn_up(btn_up), .btn_down(btn_down), .btn_start(btn_start),
    .rgb(rgb), .collision(collision), .score(score)
  );

  typedef struct {
    int xx; int yy; bit vid; logic [11:0] exp_rgb; string name;
  } pix_vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reload();
    m_py = 200; m_score = 0; m_fc = 0;
    for (int i = 0; i < 4; i++) m_ox[i] = 400 + 60 * i;
  endtask

  function automatic bit m_in_box(int xx, int yy);
    return (xx >= 40) && (xx < 90) && (yy >= m_py) && (yy < m_py + 50);
  endfunction

  function automatic bit m_in_obs(int xx, int yy);
    for (int i = 0; i < 4; i++)
      if (yy >= 60 + 100 * i && yy < 90 + 100 * i && xx >= m_ox[i] && xx < m_ox[i] + 150 && xx < 640)
        return 1'b1;
    return 1'b0;
  endfunction

  // One clock cycle with the given inputs; the model advances alongside.
  task automatic step(input bit pt, input bit vid, input int xx, input int yy,
                      input bit up, input bit dn, input bit st);
    bit tick, ovl, box, obs;
    int wraps;
    p_tick = pt; video_on = vid; x = 10'(xx); y = 10'(yy);
    btn_up = up; btn_down = dn; btn_start = st;
    tick = pt && xx == 0 && yy == 480;
    box  = m_in_box(xx, yy);
    obs  = m_in_obs(xx, yy);
    ovl  = box && obs;
    if (pt) begin
      if (!vid) m_rgb = 'h000;
      else if (c_BAR && yy < 8 && xx < 2 * m_score) m_rgb = 'h0FF;
      else if (box) m_rgb = (m_state == c_HIT && (m_fc % 2) == 1) ? 'hFFF : 'h0F0;
      else if (obs) m_rgb = 'h00F;
      else m_rgb = 'h000;
    end
    case (m_state)
      c_IDLE: if (tick && st) m_state = c_PLAY;
      c_PLAY: if (tick) begin
        wraps = 0;
        for (int i = 0; i < 4; i++) begin
          if (m_ox[i] < 2) begin m_ox[i] = 640; wraps++; end
          else m_ox[i] -= 2;
        end
        m_score = (m_score + wraps > 255) ? 255 : m_score + wraps;
        if (up && !dn) m_py = (m_py - 2 < 0) ? 0 : m_py - 2;
        if (dn && !up) m_py = (m_py + 2 > 430) ? 430 : m_py + 2;
        if (m_hit) begin m_state = c_HIT; m_fc = 0; end
      end
      c_HIT: if (tick) begin
        m_fc++;
        if (m_fc == 32) m_state = c_OVER;
      end
      default: if (st) begin model_reload(); m_state = c_IDLE; end
    endcase
    if (tick) m_hit = 1'b0;
    else if (vid && pt && ovl) m_hit = 1'b1;
    @(posedge clk);
    #1;
    p_tick = 1'b0; btn_start = 1'b0;
  endtask

  task automatic tick(input bit up, input bit dn, input bit st);
    step(1'b1, 1'b0, 0, 480, up, dn, st);
  endtask

  task automatic pix(input int xx, input int yy, input bit vid);
    step(1'b1, vid, xx, yy, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic force_obs(input int a0, input int a1, input int a2, input int a3);
    f_obs[0] = 10'(a0); f_obs[1] = 10'(a1); f_obs[2] = 10'(a2); f_obs[3] = 10'(a3);
    force dut.r_obs_x = f_obs;
    #1;
    release dut.r_obs_x;
    m_ox[0] = a0; m_ox[1] = a1; m_ox[2] = a2; m_ox[3] = a3;
  endtask

  task automatic force_score(input int s);
    f_score = 8'(s);
    force dut.r_score = f_score;
    #1;
    release dut.r_score;
    m_score = s;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    m_state = c_IDLE; m_hit = 1'b0; m_rgb = 0;
    model_reload();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    pix_vec_t vecs[14];
    int n, ox0;
    bit found;

    vecs[0]  = '{45, 210, 1'b1, 12'h0F0, "box_inner"};
    vecs[1]  = '{45, 210, 1'b0, 12'h000, "blank_video_off"};
    vecs[2]  = '{400, 60, 1'b1, 12'h00F, "obs0_left_edge"};
    vecs[3]  = '{399, 60, 1'b1, 12'h000, "obs0_left_out"};
    vecs[4]  = '{549, 89, 1'b1, 12'h00F, "obs0_right_edge"};
    vecs[5]  = '{550, 60, 1'b1, 12'h000, "obs0_right_out"};
    vecs[6]  = '{460, 160, 1'b1, 12'h00F, "obs1_top"};
    vecs[7]  = '{460, 190, 1'b1, 12'h000, "obs1_below"};
    vecs[8]  = '{639, 360, 1'b1, 12'h00F, "obs3_clip_in"};
    vecs[9]  = '{40, 249, 1'b1, 12'h0F0, "box_bottom_left"};
    vecs[10] = '{40, 250, 1'b1, 12'h000, "box_below"};
    vecs[11] = '{39, 200, 1'b1, 12'h000, "box_left_out"};
    vecs[12] = '{89, 200, 1'b1, 12'h0F0, "box_right_edge"};
    vecs[13] = '{90, 200, 1'b1, 12'h000, "box_right_out"};

    // Reset values
    do_reset();
    chk("rst_rgb", rgb, 12'h000);
    chk("rst_collision", collision, 1'b0);
    chk("rst_score", score, 8'd0);
    chk("rst_state", dut.r_state, c_IDLE);
    chk("rst_py", dut.r_py, 200);
    chk("rst_ox0", dut.r_obs_x[0], 400);
    chk("rst_ox3", dut.r_obs_x[3], 580);

    for (int i = 0; i < 14; i++) begin
      pix(vecs[i].xx, vecs[i].yy, vecs[i].vid);
      chk(vecs[i].name, rgb, vecs[i].exp_rgb);
    end

    // Start and scroll
    tick(1'b0, 1'b0, 1'b0);
    chk("idle_no_start", dut.r_state, c_IDLE);
    tick(1'b0, 1'b0, 1'b1);
    chk("start_state", dut.r_state, c_PLAY);
    chk("start_ox0", dut.r_obs_x[0], 400);
    tick(1'b0, 1'b0, 1'b0);
    chk("scroll_ox0_1", dut.r_obs_x[0], 398);
    tick(1'b0, 1'b0, 1'b0);
    chk("scroll_ox0_2", dut.r_obs_x[0], 396);

    pix(45, 210, 1'b1);
    chk("play_box_pix", rgb, 12'h0F0);
    pix(45, 210, 1'b0);
    chk("play_video_off", rgb, 12'h000);

    // Wrap and score saturation
    force_obs(1, 458, 518, 578);
    tick(1'b0, 1'b0, 1'b0);
    chk("wrap_ox0", dut.r_obs_x[0], 640);
    chk("wrap_score1", score, 1);
    force_obs(1, 1, 516, 576);
    tick(1'b0, 1'b0, 1'b0);
    chk("wrap_two_score", score, 3);
    chk("wrap_two_ox1", dut.r_obs_x[1], 640);
    force_score(254);
    force_obs(1, 1, 514, 574);
    tick(1'b0, 1'b0, 1'b0);
    chk("score_sat", score, 255);
    force_obs(1, 638, 512, 572);
    tick(1'b0, 1'b0, 1'b0);
    chk("score_hold_255", score, 255);

    // Player clamping
    repeat (120) tick(1'b1, 1'b0, 1'b0);
    chk("py_top_clamp", dut.r_py, 0);
    repeat (250) tick(1'b0, 1'b1, 1'b0);
    chk("py_bot_clamp", dut.r_py, 430);
    repeat (5) tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    chk("py_both_held", dut.r_py, 420);
    chk("score_model", score, m_score);

    // Collision with obstacle 1 (rows 160..189)
    repeat (125) tick(1'b1, 1'b0, 1'b0);
    chk("py_at_170", dut.r_py, 170);
    found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      if (m_ox[1] >= 0 && m_ox[1] <= 45) found = 1'b1;
      else tick(1'b0, 1'b0, 1'b0);
    end
    chk("obs1_reached_box", found, 1'b1);
    pix(45, 175, 1'b1);
    chk("overlap_box_priority", rgb, 12'h0F0);
    chk("no_hit_before_tick", collision, 1'b0);
    tick(1'b0, 1'b0, 1'b0);
    chk("hit_state", dut.r_state, c_HIT);
    chk("hit_collision", collision, 1'b1);
    ox0 = m_ox[0];
    tick(1'b0, 1'b0, 1'b0);
    pix(45, 175, 1'b1);
    chk("hit_flash_odd", rgb, 12'hFFF);
    repeat (30) tick(1'b1, 1'b0, 1'b0);
    chk("hit_31_frames", dut.r_state, c_HIT);
    chk("hit_frozen_ox0", dut.r_obs_x[0], ox0);
    chk("hit_frozen_py", dut.r_py, 170);
    tick(1'b0, 1'b0, 1'b0);
    chk("over_state", dut.r_state, c_OVER);
    chk("over_collision", collision, 1'b1);
    step(1'b0, 1'b0, 5, 5, 1'b0, 1'b0, 1'b1);
    chk("reload_state", dut.r_state, c_IDLE);
    chk("reload_py", dut.r_py, 200);
    chk("reload_ox0", dut.r_obs_x[0], 400);
    chk("reload_score", score, 0);
    chk("reload_collision", collision, 1'b0);

    // Asynchronous reset mid-line
    tick(1'b0, 1'b0, 1'b1);
    pix(45, 210, 1'b1);
    chk("pre_reset_rgb", rgb, 12'h0F0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", rgb, 12'h000);
    chk("async_rst_state", dut.r_state, c_IDLE);
    #1 reset_n = 1'b1;
    m_state = c_IDLE; m_hit = 1'b0; m_rgb = 0;
    model_reload();
    @(posedge clk);
    #1;
    tick(1'b0, 1'b0, 1'b1);
    chk("post_rst_start", dut.r_state, c_PLAY);
    tick(1'b0, 1'b0, 1'b0);
    chk("post_rst_ox0", dut.r_obs_x[0], 398);

    // Score bar pixels
    force_score(10);
    pix(19, 3, 1'b1);
    chk("bar_19_3", rgb, c_BAR ? 12'h0FF : 12'h000);
    pix(20, 3, 1'b1);
    chk("bar_20_3", rgb, 12'h000);

    // Randomized play against the model
    do_reset();
    tick(1'b0, 1'b0, 1'b1);
    for (int f = 0; f < 400; f++) begin
      for (int p = 0; p < 4; p++) begin
        int xx, yy;
        if ($urandom_range(0, 2) == 0) begin
          xx = 40 + $urandom_range(0, 49);
          yy = m_py + $urandom_range(0, 49);
        end else begin
          xx = $urandom_range(0, 639);
          yy = $urandom_range(0, 479);
        end
        step(1'b1, $urandom_range(0, 3) != 0, xx, yy, 1'b0, 1'b0, $urandom_range(0, 19) == 0);
        chk("rnd_rgb", rgb, m_rgb);
      end
      n = $urandom_range(0, 3);
      tick(n[0], n[1], $urandom_range(0, 1) == 1);
      chk("rnd_collision", collision, (m_state == c_HIT || m_state == c_OVER));
      chk("rnd_score", score, m_score);
      chk("rnd_py", dut.r_py, m_py);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
